// File: rtl/cache_types.sv
// Types and default widths shared by the cache-side memory interface blocks.
package cache_types;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } cla_state_t;

  localparam int unsigned S_LINE_DEFAULT  = 256;
  localparam int unsigned S_BURST_DEFAULT = 64;

endpackage

// File: rtl/cacheline_adapter.sv
// Converts 256-bit cache line fills/writebacks into 4-beat 64-bit memory bursts.
module cacheline_adapter
  import cache_types::*;
#(
  parameter int unsigned s_line   = S_LINE_DEFAULT,
  parameter int unsigned s_burst  = S_BURST_DEFAULT,
  parameter int unsigned s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [s_line-1:0]   line_i,
  output logic [s_line-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [s_burst-1:0]  burst_i,
  output logic [s_burst-1:0]  burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned CW        = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(num_beats - 1);
  localparam logic [31:0]   OFF_MASK  = 32'((64'd1 << s_offset) - 64'd1);

  cla_state_t        r_state;
  logic [CW-1:0]     r_count;
  logic [s_line-1:0] r_line;
  logic [31:0]       r_addr;

  logic              w_last;

  assign w_last = (r_count == LAST_BEAT);

  // One buffer serves both directions: fill beats land in it, writeback data is latched into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_line  <= '0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i) begin
            r_addr  <= address_i;
            r_state <= READ;
          end else if (write_i) begin
            r_addr  <= address_i;
            r_line  <= line_i;
            r_state <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            r_line[r_count*s_burst +: s_burst] <= burst_i;
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        DONE: begin
          r_count <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_count <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    read_o    = (r_state == READ);
    write_o   = (r_state == WRITE);
    resp_o    = (r_state == DONE);
    line_o    = r_line;
    burst_o   = r_line[r_count*s_burst +: s_burst];
    address_o = r_addr & ~OFF_MASK;
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: stimulus queues expectations, a negedge monitor checks them.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] line;
    int           cyc;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] wq[$];
  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  cacheline_adapter #(
    .s_line  (256),
    .s_burst (64),
    .s_offset(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_o && write_o) chk("rd_wr_exclusive", 1, 0);
      if ((read_o || write_o) && expq.size() > 0) chk("address_o", address_o, expq[0].addr);
      if (write_o) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_beat", 1, 0);
        end else begin
          chk("burst_o", burst_o, wq[0]);
          if (resp_i) void'(wq.pop_front());
        end
      end
      if (resp_o) begin
        if (expq.size() == 0) begin
          chk("unexpected_resp_o", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("resp_cycle", cyc, e.cyc);
          if (e.rd) chk("line_o", line_o, e.line);
        end
      end
    end
  end

  // Called one time unit after a rising edge; returns in the DONE cycle with requests dropped.
  task automatic xfer(input bit rd, input logic [31:0] addr, input logic [31:0] exp_addr,
                      input logic [255:0] data, input int gap, input bit hold_wr);
    exp_t e;
    e.rd   = rd;
    e.addr = exp_addr;
    e.line = data;
    e.cyc  = cyc + 5 + 3 * gap;
    expq.push_back(e);
    if (!rd) for (int k = 0; k < 4; k++) wq.push_back(data[k*64 +: 64]);
    read_i    = rd;
    write_i   = !rd || hold_wr;
    address_i = addr;
    line_i    = rd ? {8{$urandom}} : data;
    @(posedge clk) #1;
    chk("read_o_active", read_o, rd);
    chk("write_o_active", write_o, !rd);
    address_i = $urandom;
    line_i    = {8{$urandom}};
    for (int k = 0; k < 4; k++) begin
      resp_i  = 1'b1;
      burst_i = rd ? data[k*64 +: 64] : {$urandom, $urandom};
      @(posedge clk) #1;
      resp_i  = 1'b0;
      burst_i = {$urandom, $urandom};
      if (k < 3) repeat (gap) @(posedge clk) #1;
    end
    read_i  = 1'b0;
    write_i = hold_wr;
  endtask

  initial begin
    rst       = 1'b1;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    #2;
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_line_o", line_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_address_o", address_o, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;

    // Read, no wait states
    xfer(1'b1, 32'h1234_5678, 32'h1234_5660,
         {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #1;

    // Write with alternating wait states
    xfer(1'b0, 32'h8000_0040, 32'h8000_0040,
         256'hFFEEDDCCBBAA9988_7766554433221100_0F0E0D0C0B0A0908_07060504DDCCBBAA, 1, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #1;

    // Simultaneous read and write: read first, write left pending
    xfer(1'b1, 32'h0000_1000, 32'h0000_1000,
         {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
          64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000}, 0, 1'b1);
    @(posedge clk) #1;
    xfer(1'b0, 32'h0000_203F, 32'h0000_2020,
         {64'hB3B3_0000_1111_0003, 64'hB2B2_0000_1111_0002,
          64'hB1B1_0000_1111_0001, 64'hB0B0_0000_1111_0000}, 0, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #1;

    // Back-to-back: write issued the cycle after resp_o
    xfer(1'b1, 32'hCAFE_001F, 32'hCAFE_0000,
         {64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0003,
          64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001}, 0, 1'b0);
    @(posedge clk) #1;
    xfer(1'b0, 32'hBEEF_0123, 32'hBEEF_0120,
         {64'hD4D4_D4D4_D4D4_D4D4, 64'hD3D3_D3D3_D3D3_D3D3,
          64'hD2D2_D2D2_D2D2_D2D2, 64'hD1D1_D1D1_D1D1_D1D1}, 0, 1'b0);
    repeat (10) @(posedge clk) #1;
    chk("b2b_no_extra_burst", expq.size(), 0);

    // Asynchronous reset after two read beats
    read_i    = 1'b1;
    address_i = 32'h5555_5555;
    @(posedge clk) #1;
    resp_i  = 1'b1;
    burst_i = 64'hEEEE_0000_0000_0001;
    @(posedge clk) #1;
    burst_i = 64'hEEEE_0000_0000_0002;
    @(posedge clk) #1;
    resp_i = 1'b0;
    read_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_read_o", read_o, 0);
    chk("midrst_resp_o", resp_o, 0);
    chk("midrst_line_o", line_o, 0);
    chk("midrst_address_o", address_o, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(posedge clk) #1;
    xfer(1'b1, 32'h0000_0ABC, 32'h0000_0AA0,
         {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 0, 1'b0);
    @(posedge clk) #1;
    @(posedge clk) #1;

    // Spurious resp_i while idle, then a read with wait states
    for (int k = 0; k < 3; k++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(posedge clk) #1;
      chk("idle_spurious_read_o", read_o, 0);
      chk("idle_spurious_write_o", write_o, 0);
    end
    resp_i = 1'b0;
    @(posedge clk) #1;
    xfer(1'b1, 32'h0000_0005, 32'h0000_0000,
         {64'h9999_0000_0000_0004, 64'h8888_0000_0000_0003,
          64'h7777_0000_0000_0002, 64'h6666_0000_0000_0001}, 2, 1'b0);
    repeat (5) @(posedge clk) #1;

    chk("expq_drained", expq.size(), 0);
    chk("wbeat_q_drained", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
